// File: rtl/output_backprop_seq.sv
// output_backprop_seq
//   Output-neuron weight updater for the training path. It holds N_HID signed
//   weights and, on start_i, applies one SGD step to every weight, one weight
//   per clock:
//     w[i] <= w[i] - ((2*(final-target)*h[i]) >>> LR_SHIFT)
//   It sits between the training sequencer and the forward-pass MAC, which
//   reads weights through the combinational read port.
//
//   Build option: define OBP_SAT_EN to clamp each updated weight to the signed
//   WW-bit range and report clamping on sat_o. Without it, results wrap to the
//   low WW bits and sat_o is tied low.
//
// Ports
//   clk_i      clock, rising edge
//   rst_i      asynchronous reset, active low
//   clr_i      synchronous clear: zero all weights, abort any step
//   start_i    begin one update step (accepted only in IDLE)
//   target_i   training target (unsigned, TW bits)
//   final_i    forward-pass output (unsigned, FW bits)
//   hid_i      packed hidden values, h[i] = hid_i[i*HW +: HW]
//   wr_en_i    weight load strobe (honoured only in IDLE)
//   wr_idx_i   weight load index
//   wr_data_i  weight load value
//   rd_idx_i   weight read index
//   w_rd_o     w[rd_idx_i], or 0 when the index is out of range
//   busy_o     high while a step is in progress (CALC/UPD/DONE)
//   done_o     one-cycle pulse when a step completes
//   sat_o      sticky per step: some update clamped
//
// State    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting; weight loads accepted; start_i latches operands
// S_CALC   | register err = final - target
// S_UPD    | update w[idx], idx runs 0..N_HID-1
// S_DONE   | last weight written; done_o pulses on the way back to IDLE

module output_backprop_seq #(
  parameter int N_HID    = 4,
  parameter int TW       = 4,
  parameter int FW       = 8,
  parameter int HW       = 10,
  parameter int WW       = 8,
  parameter int LR_SHIFT = 4,
  localparam int IW      = (N_HID > 1) ? $clog2(N_HID) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              start_i,
  input  logic [TW-1:0]     target_i,
  input  logic [FW-1:0]     final_i,
  input  logic [N_HID*HW-1:0] hid_i,
  input  logic              wr_en_i,
  input  logic [IW-1:0]     wr_idx_i,
  input  logic [WW-1:0]     wr_data_i,
  input  logic [IW-1:0]     rd_idx_i,
  output logic [WW-1:0]     w_rd_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              sat_o
);

  // err needs one bit over the wider operand; the product carries the error,
  // the zero-extended hidden value and the factor of two without overflow.
  localparam int EW = ((TW > FW) ? TW : FW) + 1;
  localparam int PW = EW + HW + 2;
  localparam int SW = ((PW > WW) ? PW : WW) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_UPD, S_DONE} state_t;

  state_t               state;
  logic signed [WW-1:0] w    [N_HID];
  logic [HW-1:0]        h_q  [N_HID];
  logic [TW-1:0]        target_q;
  logic [FW-1:0]        final_q;
  logic signed [EW-1:0] err;
  logic [IW-1:0]        idx;
  logic                 done;

  logic [HW-1:0]        h_cur;
  logic signed [WW-1:0] w_cur;
  logic signed [PW-1:0] err_x;
  logic signed [PW-1:0] h_x;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] delta;
  logic signed [SW-1:0] sum;
  logic [WW-1:0]        w_new;

`ifdef OBP_SAT_EN
  localparam logic signed [SW-1:0] W_MAX = {{(SW-WW+1){1'b0}}, {(WW-1){1'b1}}};
  localparam logic signed [SW-1:0] W_MIN = {{(SW-WW+1){1'b1}}, {(WW-1){1'b0}}};
  logic clamp;
  logic sat;
`else
  logic unused_sum_bits;
`endif

  // Update datapath for the weight currently addressed by idx.
  always_comb begin
    h_cur = h_q[idx];
    w_cur = w[idx];
    err_x = PW'(err);
    h_x   = PW'({1'b0, h_cur});
    prod  = (err_x * h_x) <<< 1;
    delta = prod >>> LR_SHIFT;          // floors toward -inf
    sum   = SW'(w_cur) - SW'(delta);
    w_new = sum[WW-1:0];
`ifdef OBP_SAT_EN
    clamp = 1'b0;
    if (sum > W_MAX) begin
      w_new = W_MAX[WW-1:0];
      clamp = 1'b1;
    end else if (sum < W_MIN) begin
      w_new = W_MIN[WW-1:0];
      clamp = 1'b1;
    end
`endif
  end

`ifndef OBP_SAT_EN
  // Wrap mode discards the upper sum bits by design.
  assign unused_sum_bits = ^sum[SW-1:WW];
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= S_IDLE;
      idx      <= '0;
      err      <= '0;
      target_q <= '0;
      final_q  <= '0;
      done     <= 1'b0;
      for (int i = 0; i < N_HID; i++) begin
        w[i]   <= '0;
        h_q[i] <= '0;
      end
`ifdef OBP_SAT_EN
      sat      <= 1'b0;
`endif
    end else if (clr_i) begin
      state <= S_IDLE;
      idx   <= '0;
      done  <= 1'b0;
      for (int i = 0; i < N_HID; i++) w[i] <= '0;
`ifdef OBP_SAT_EN
      sat   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // A load in the same cycle as start lands first, so the step sees it.
          if (wr_en_i && (int'(wr_idx_i) < N_HID)) w[wr_idx_i] <= wr_data_i;
          if (start_i) begin
            target_q <= target_i;
            final_q  <= final_i;
            for (int i = 0; i < N_HID; i++) h_q[i] <= hid_i[i*HW +: HW];
`ifdef OBP_SAT_EN
            sat      <= 1'b0;
`endif
            state    <= S_CALC;
          end
        end
        S_CALC: begin
          err   <= $signed(EW'(final_q)) - $signed(EW'(target_q));
          idx   <= '0;
          state <= S_UPD;
        end
        S_UPD: begin
          w[idx] <= w_new;
`ifdef OBP_SAT_EN
          if (clamp) sat <= 1'b1;
`endif
          if (int'(idx) == N_HID - 1) begin
            idx   <= '0;
            state <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign w_rd_o = (int'(rd_idx_i) < N_HID) ? w[rd_idx_i] : '0;
  assign busy_o = (state != S_IDLE);
  assign done_o = done;
`ifdef OBP_SAT_EN
  assign sat_o  = sat;
`else
  assign sat_o  = 1'b0;
`endif

endmodule

// File: tb/tb_output_backprop_seq.sv
module tb_output_backprop_seq;

  localparam int N_HID = 4;
  localparam int TW    = 4;
  localparam int FW    = 8;
  localparam int HW    = 10;
  localparam int WW    = 8;

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b0;
  logic                clr_i = 1'b0;
  logic                start_i = 1'b0;
  logic [TW-1:0]       target_i = '0;
  logic [FW-1:0]       final_i = '0;
  logic [N_HID*HW-1:0] hid_i = '0;
  logic                wr_en_i = 1'b0;
  logic [1:0]          wr_idx_i = '0;
  logic [WW-1:0]       wr_data_i = '0;
  logic [1:0]          rd_idx_i = '0;
  logic [WW-1:0]       w_rd_o;
  logic                busy_o;
  logic                done_o;
  logic                sat_o;

  output_backprop_seq dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (clr_i),
    .start_i   (start_i),
    .target_i  (target_i),
    .final_i   (final_i),
    .hid_i     (hid_i),
    .wr_en_i   (wr_en_i),
    .wr_idx_i  (wr_idx_i),
    .wr_data_i (wr_data_i),
    .rd_idx_i  (rd_idx_i),
    .w_rd_o    (w_rd_o),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .sat_o     (sat_o)
  );

  always #10 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;
  int mw [N_HID];        // reference copy of the weights
  int exp_q [$];         // scoreboard: N_HID weights then the sat flag per step

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference update: floor division by 16, then clamp or wrap to 8 bits.
  function automatic int model(input int w, input int err, input int h, output bit s);
    int p, d, sum;
    p = 2 * err * h;
    d = (p >= 0) ? (p / 16) : -((-p + 15) / 16);
    sum = w - d;
    s = 1'b0;
`ifdef OBP_SAT_EN
    if (sum > 127) begin sum = 127; s = 1'b1; end
    if (sum < -128) begin sum = -128; s = 1'b1; end
`else
    sum = ((sum % 256) + 256) % 256;
    if (sum > 127) sum = sum - 256;
`endif
    return sum;
  endfunction

  task automatic chk_w(input string tag, input int i, input int e);
    logic [7:0] e8;
    e8 = e[7:0];
    rd_idx_i = i[1:0];
    #1;
    chk($sformatf("%s_w%0d", tag, i), w_rd_o, e8);
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N_HID; i++) chk_w(tag, i, mw[i]);
  endtask

  task automatic wr_w(input int i, input int d);
    @(negedge clk_i);
    wr_en_i = 1'b1;
    wr_idx_i = i[1:0];
    wr_data_i = d[7:0];
    @(posedge clk_i); #1;
    wr_en_i = 1'b0;
    mw[i] = d;
  endtask

  task automatic run_step(input string tag, input int tgt, input int fin,
                          input int h0, input int h1, input int h2, input int h3,
                          input bit wr_same, input int wr_i, input int wr_d,
                          input bit disturb);
    int hv [N_HID];
    int err, done_k, busy_n, e;
    bit s, s_any;
    logic [7:0] e8;
    hv = '{h0, h1, h2, h3};
    if (wr_same) mw[wr_i] = wr_d;
    err = fin - tgt;
    s_any = 1'b0;
    for (int i = 0; i < N_HID; i++) begin
      mw[i] = model(mw[i], err, hv[i], s);
      s_any |= s;
      exp_q.push_back(mw[i]);
    end
    exp_q.push_back(int'(s_any));

    @(negedge clk_i);
    target_i = tgt[TW-1:0];
    final_i = fin[FW-1:0];
    hid_i = {hv[3][9:0], hv[2][9:0], hv[1][9:0], hv[0][9:0]};
    start_i = 1'b1;
    wr_en_i = wr_same;
    wr_idx_i = wr_i[1:0];
    wr_data_i = wr_d[7:0];
    rd_idx_i = 2'd0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    wr_en_i = 1'b0;
    busy_n = busy_o ? 1 : 0;
    done_k = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk_i); #1;
      if (k == 2) begin
        // w[0] was written on this edge and must already be visible.
        e8 = mw[0][7:0];
        chk({tag, "_live_w0"}, w_rd_o, e8);
      end
      if (disturb && k == 2) begin
        start_i = 1'b1;
        target_i = '0;
        final_i = 8'hFF;
        hid_i = '1;
        wr_en_i = 1'b1;
        wr_idx_i = 2'd0;
        wr_data_i = 8'd77;
      end
      if (disturb && k == 3) begin
        start_i = 1'b0;
        wr_en_i = 1'b0;
      end
      if (busy_o) busy_n++;
      if (done_o) begin
        done_k = k;
        break;
      end
    end
    chk({tag, "_latency"}, done_k, 6);
    chk({tag, "_busy_cycles"}, busy_n, 6);
    @(posedge clk_i); #1;
    chk({tag, "_done_pulse"}, done_o, 1'b0);
    chk({tag, "_idle_after"}, busy_o, 1'b0);
    for (int i = 0; i < N_HID; i++) begin
      e = exp_q.pop_front();
      chk_w(tag, i, e);
    end
    e = exp_q.pop_front();
    chk({tag, "_sat"}, sat_o, e[0]);
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < N_HID; i++) mw[i] = 0;

    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_sat", sat_o, 1'b0);
    check_all("rst");

    // Directed vectors
    wr_w(0, 10);
    run_step("basic", 3, 5, 4, 0, 0, 0, 1'b0, 0, 0, 1'b0);       // w0 -> 9
    run_step("neg_err", 15, 3, 0, 0, 8, 0, 1'b0, 0, 0, 1'b0);    // w2 -> 12
    wr_w(1, -120);
    run_step("big", 0, 200, 0, 1000, 0, 0, 1'b0, 0, 0, 1'b0);    // clamp -128 or wrap -32

    // Random vectors
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N_HID; i++) wr_w(i, int'($urandom_range(255)) - 128);
      run_step($sformatf("rand%0d", r), int'($urandom_range(15)), int'($urandom_range(255)),
               int'($urandom_range(1023)), int'($urandom_range(1023)),
               int'($urandom_range(1023)), int'($urandom_range(1023)),
               1'b0, 0, 0, 1'b0);
    end

    // Load and start together: step must use the newly loaded w3 = 50.
    run_step("wr_same", 4, 2, 0, 0, 0, 16, 1'b1, 3, 50, 1'b0);
    // start/load pulsed mid-step must be ignored.
    run_step("busy_ign", 1, 9, 3, 5, 7, 9, 1'b0, 0, 0, 1'b1);

    // Synchronous clear three cycles into a step.
    for (int i = 0; i < N_HID; i++) wr_w(i, 20 + i);
    @(negedge clk_i);
    target_i = 4'd0; final_i = 8'd100; hid_i = '1; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    clr_i = 1'b1;
    @(posedge clk_i); #1;
    clr_i = 1'b0;
    chk("clr_busy", busy_o, 1'b0);
    chk("clr_done", done_o, 1'b0);
    for (int i = 0; i < N_HID; i++) mw[i] = 0;
    check_all("clr");
    chk("clr_sat", sat_o, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk_i); #1;
      if (done_o) seen = 1'b1;
    end
    chk("clr_no_done", seen, 1'b0);

    // Asynchronous reset in the middle of a step.
    for (int i = 0; i < N_HID; i++) wr_w(i, -5 - i);
    @(negedge clk_i);
    target_i = 4'd2; final_i = 8'd30; hid_i = '1; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i); #3;
    rst_i = 1'b0;
    #1;
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_done", done_o, 1'b0);
    for (int i = 0; i < N_HID; i++) mw[i] = 0;
    check_all("arst");
    @(negedge clk_i);
    rst_i = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk_i); #1;
      if (done_o || busy_o) seen = 1'b1;
    end
    chk("arst_quiet", seen, 1'b0);

    // Normal operation after reset.
    wr_w(2, 7);
    run_step("recover", 10, 0, 0, 0, 100, 0, 1'b0, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
